// File: rtl/game_pkg.sv
// Shared encodings for the frame scheduler: renderer phases, client indices,
// VGA field widths and default timing constants.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH0  = 2'd1,
    PH1  = 2'd2,
    PH2  = 2'd3
  } phase_e;

  localparam int CLIENT_BG  = 0;
  localparam int CLIENT_OBS = 1;
  localparam int CLIENT_RUN = 2;
  localparam int N_CLIENT   = 3;

  localparam int VGA_XW = 8;
  localparam int VGA_YW = 7;
  localparam int VGA_CW = 3;

  localparam int TICK_DIV_DEFAULT = 3000000;
  localparam int WDOG_MAX_DEFAULT = 20000;

  function automatic logic [N_CLIENT-1:0] phase_grant(input phase_e p);
    case (p)
      PH0:     phase_grant = 3'b001;
      PH1:     phase_grant = 3'b010;
      PH2:     phase_grant = 3'b100;
      default: phase_grant = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Game tick generator: one-cycle registered pulse every TICK_DIV cycles while run is high.
module tick_divider
  import game_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Holding the counter at RELOAD while stopped makes the first tick land TICK_DIV cycles after run rises.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt  <= RELOAD;
      tick <= 1'b0;
    end else if (!run) begin
      cnt  <= RELOAD;
      tick <= 1'b0;
    end else if (cnt == '0) begin
      cnt  <= RELOAD;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt - CW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/vga_frame_scheduler.sv
// Shares the single VGA write port among three renderers per frame and generates the game tick.
// Optional VGA_FRAME_STATS_EN adds frame and overrun counters; otherwise those ports read 0.
module vga_frame_scheduler
  import game_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int WDOG_MAX = WDOG_MAX_DEFAULT
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       run,
  output logic                       tick,
  input  logic [N_CLIENT-1:0]        req,
  input  logic [N_CLIENT-1:0]        done,
  input  logic [N_CLIENT*VGA_XW-1:0] cx,
  input  logic [N_CLIENT*VGA_YW-1:0] cy,
  input  logic [N_CLIENT*VGA_CW-1:0] ccol,
  output logic [N_CLIENT-1:0]        grant,
  output logic [VGA_XW-1:0]          vga_x,
  output logic [VGA_YW-1:0]          vga_y,
  output logic [VGA_CW-1:0]          vga_colour,
  output logic                       vga_plot,
  output logic                       busy,
  output logic                       overrun,
  output logic                       timeout,
  output logic [7:0]                 frame_count,
  output logic [7:0]                 overrun_count
);

  localparam int WW = (WDOG_MAX > 1) ? $clog2(WDOG_MAX) : 1;

  phase_e          state, state_nxt;
  logic [WW-1:0]   wdog;
  logic            cur_req, cur_done, wdog_exp, skip, phase_exit, wdog_exit;
  logic            vld_p0;
  logic [VGA_XW-1:0] x_p0;
  logic [VGA_YW-1:0] y_p0;
  logic [VGA_CW-1:0] col_p0;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick_divider (
    .clk    (clk),
    .resetn (resetn),
    .run    (run),
    .tick   (tick)
  );

  assign busy = (state != IDLE);

  always_comb begin
    cur_req  = 1'b0;
    cur_done = 1'b0;
    case (state)
      PH0: begin cur_req = req[CLIENT_BG];  cur_done = done[CLIENT_BG];  end
      PH1: begin cur_req = req[CLIENT_OBS]; cur_done = done[CLIENT_OBS]; end
      PH2: begin cur_req = req[CLIENT_RUN]; cur_done = done[CLIENT_RUN]; end
      default: ;
    endcase
    // A phase whose client had nothing to draw on entry is dropped after its first cycle.
    skip       = busy && (wdog == '0) && !cur_req;
    wdog_exp   = busy && (wdog == WW'(WDOG_MAX - 1));
    phase_exit = skip || (busy && cur_done) || wdog_exp;
    wdog_exit  = wdog_exp && !skip && !cur_done;

    state_nxt = state;
    case (state)
      IDLE:    if (tick)       state_nxt = PH0;
      PH0:     if (phase_exit) state_nxt = PH1;
      PH1:     if (phase_exit) state_nxt = PH2;
      PH2:     if (phase_exit) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      grant   <= '0;
      wdog    <= '0;
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      grant <= phase_grant(state_nxt);
      if (state_nxt != state) wdog <= '0;
      else if (busy)          wdog <= wdog + WW'(1);
      if (wdog_exit)     timeout <= 1'b1;
      if (tick && busy)  overrun <= 1'b1;
    end
  end

  // Stage p0: select the granted client's pixel.
  always_comb begin
    vld_p0 = |(grant & req);
    x_p0   = cx[CLIENT_BG*VGA_XW +: VGA_XW];
    y_p0   = cy[CLIENT_BG*VGA_YW +: VGA_YW];
    col_p0 = ccol[CLIENT_BG*VGA_CW +: VGA_CW];
    if (grant[CLIENT_OBS]) begin
      x_p0   = cx[CLIENT_OBS*VGA_XW +: VGA_XW];
      y_p0   = cy[CLIENT_OBS*VGA_YW +: VGA_YW];
      col_p0 = ccol[CLIENT_OBS*VGA_CW +: VGA_CW];
    end
    if (grant[CLIENT_RUN]) begin
      x_p0   = cx[CLIENT_RUN*VGA_XW +: VGA_XW];
      y_p0   = cy[CLIENT_RUN*VGA_YW +: VGA_YW];
      col_p0 = ccol[CLIENT_RUN*VGA_CW +: VGA_CW];
    end
  end

  // Stage p1: registered VGA write port; coordinates hold between plots.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      vga_plot <= vld_p0;
      if (vld_p0) begin
        vga_x      <= x_p0;
        vga_y      <= y_p0;
        vga_colour <= col_p0;
      end
    end
  end

`ifdef VGA_FRAME_STATS_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      frame_count   <= '0;
      overrun_count <= '0;
    end else begin
      if (state == PH2 && phase_exit)            frame_count   <= frame_count + 8'd1;
      if (tick && busy && overrun_count != 8'hFF) overrun_count <= overrun_count + 8'd1;
    end
  end
`else
  assign frame_count   = '0;
  assign overrun_count = '0;
`endif

endmodule
